// File: rtl/datapath_pkg.sv
// Shared datapath widths, register-index constants and the forwarding-hit helper
// used by the ID/EX boundary logic.
package datapath_pkg;
  localparam int SIZE_DEF   = 64;
  localparam int CTRL_W_DEF = 16;
  localparam logic [4:0] X0 = 5'd0;

  // Entry slots of the ID/EX register pair
  localparam int N_ENTRY = 2;
  localparam int MAIN    = 0;
  localparam int SKID    = 1;

  function automatic logic wb_hit(logic we, logic [4:0] wb_rd, logic [4:0] rs);
    return we && (rs != X0) && (wb_rd == rs);
  endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side, execute-side and writeback buses seen by the ID/EX stage.
interface id_ex_stage_if #(
  parameter int SIZE   = datapath_pkg::SIZE_DEF,
  parameter int CTRL_W = datapath_pkg::CTRL_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [SIZE-1:0]   in_pc;
  logic [SIZE-1:0]   in_imm;
  logic [CTRL_W-1:0] in_ctrl;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [4:0]        in_rd;
  logic [SIZE-1:0]   rf_d1;
  logic [SIZE-1:0]   rf_d2;
  logic              wb_we;
  logic [4:0]        wb_rd;
  logic [SIZE-1:0]   wb_din;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [SIZE-1:0]   out_pc;
  logic [SIZE-1:0]   out_imm;
  logic [SIZE-1:0]   out_op1;
  logic [SIZE-1:0]   out_op2;
  logic [CTRL_W-1:0] out_ctrl;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic [4:0]        out_rd;

  modport master (
    output in_valid, in_pc, in_imm, in_ctrl, in_rs1, in_rs2, in_rd,
    output rf_d1, rf_d2, wb_we, wb_rd, wb_din, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_op1, out_op2,
    input  out_ctrl, out_rs1, out_rs2, out_rd
  );

  modport slave (
    input  in_valid, in_pc, in_imm, in_ctrl, in_rs1, in_rs2, in_rd,
    input  rf_d1, rf_d2, wb_we, wb_rd, wb_din, flush, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_op1, out_op2,
    output out_ctrl, out_rs1, out_rs2, out_rd
  );
endinterface

// File: rtl/operand_bypass.sv
// Writeback forwarding for one operand: x0 reads as zero, a matching writeback
// wins over the current value.
module operand_bypass
  import datapath_pkg::*;
#(
  parameter int SIZE = SIZE_DEF
) (
  input  logic [4:0]      rs,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [SIZE-1:0] wb_din,
  input  logic [SIZE-1:0] cur,
  output logic [SIZE-1:0] nxt
);
  always_comb begin
    nxt = cur;
    if (rs == X0)
      nxt = '0;
    else if (wb_hit(wb_we, wb_rd, rs))
      nxt = wb_din;
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with a one-deep skid buffer; held operands keep
// snooping the writeback bus so they never go stale while stalled.
module id_ex_stage
  import datapath_pkg::*;
#(
  parameter int SIZE   = SIZE_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  id_ex_stage_if.slave bus
);
  logic              valid_reg [N_ENTRY];
  logic [SIZE-1:0]   pc_reg    [N_ENTRY];
  logic [SIZE-1:0]   imm_reg   [N_ENTRY];
  logic [CTRL_W-1:0] ctrl_reg  [N_ENTRY];
  logic [4:0]        rs1_reg   [N_ENTRY];
  logic [4:0]        rs2_reg   [N_ENTRY];
  logic [4:0]        rd_reg    [N_ENTRY];
  logic [SIZE-1:0]   op1_reg   [N_ENTRY];
  logic [SIZE-1:0]   op2_reg   [N_ENTRY];
  logic [SIZE-1:0]   op1_byp   [N_ENTRY];
  logic [SIZE-1:0]   op2_byp   [N_ENTRY];
  logic [SIZE-1:0]   in_op1;
  logic [SIZE-1:0]   in_op2;
  logic              push;
  logic              pop;

  // Ready depends only on the skid flop, so there is no path from out_ready.
  assign bus.in_ready  = ~valid_reg[SKID];
  assign bus.out_valid = valid_reg[MAIN];
  assign bus.out_pc    = pc_reg[MAIN];
  assign bus.out_imm   = imm_reg[MAIN];
  assign bus.out_ctrl  = ctrl_reg[MAIN];
  assign bus.out_rs1   = rs1_reg[MAIN];
  assign bus.out_rs2   = rs2_reg[MAIN];
  assign bus.out_rd    = rd_reg[MAIN];
  assign bus.out_op1   = op1_reg[MAIN];
  assign bus.out_op2   = op2_reg[MAIN];

  assign push = bus.in_valid & ~valid_reg[SKID];
  assign pop  = valid_reg[MAIN] & bus.out_ready;

  operand_bypass #(.SIZE(SIZE)) u_in_op1 (
    .rs(bus.in_rs1), .wb_we(bus.wb_we), .wb_rd(bus.wb_rd), .wb_din(bus.wb_din),
    .cur(bus.rf_d1), .nxt(in_op1)
  );
  operand_bypass #(.SIZE(SIZE)) u_in_op2 (
    .rs(bus.in_rs2), .wb_we(bus.wb_we), .wb_rd(bus.wb_rd), .wb_din(bus.wb_din),
    .cur(bus.rf_d2), .nxt(in_op2)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_ENTRY; gi++) begin : g_held
      operand_bypass #(.SIZE(SIZE)) u_op1 (
        .rs(rs1_reg[gi]), .wb_we(bus.wb_we), .wb_rd(bus.wb_rd), .wb_din(bus.wb_din),
        .cur(op1_reg[gi]), .nxt(op1_byp[gi])
      );
      operand_bypass #(.SIZE(SIZE)) u_op2 (
        .rs(rs2_reg[gi]), .wb_we(bus.wb_we), .wb_rd(bus.wb_rd), .wb_din(bus.wb_din),
        .cur(op2_reg[gi]), .nxt(op2_byp[gi])
      );
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N_ENTRY; i++) begin
        valid_reg[i] <= 1'b0;
        pc_reg[i]    <= '0;
        imm_reg[i]   <= '0;
        ctrl_reg[i]  <= '0;
        rs1_reg[i]   <= '0;
        rs2_reg[i]   <= '0;
        rd_reg[i]    <= '0;
        op1_reg[i]   <= '0;
        op2_reg[i]   <= '0;
      end
    end else if (bus.flush) begin
      valid_reg[MAIN] <= 1'b0;
      valid_reg[SKID] <= 1'b0;
    end else begin
      for (int i = 0; i < N_ENTRY; i++) begin
        op1_reg[i] <= op1_byp[i];
        op2_reg[i] <= op2_byp[i];
      end
      if (pop && valid_reg[SKID]) begin
        // Skid slides forward carrying this cycle's forwarded operands.
        pc_reg[MAIN]    <= pc_reg[SKID];
        imm_reg[MAIN]   <= imm_reg[SKID];
        ctrl_reg[MAIN]  <= ctrl_reg[SKID];
        rs1_reg[MAIN]   <= rs1_reg[SKID];
        rs2_reg[MAIN]   <= rs2_reg[SKID];
        rd_reg[MAIN]    <= rd_reg[SKID];
        op1_reg[MAIN]   <= op1_byp[SKID];
        op2_reg[MAIN]   <= op2_byp[SKID];
        valid_reg[SKID] <= 1'b0;
      end else if (push && (!valid_reg[MAIN] || pop)) begin
        pc_reg[MAIN]    <= bus.in_pc;
        imm_reg[MAIN]   <= bus.in_imm;
        ctrl_reg[MAIN]  <= bus.in_ctrl;
        rs1_reg[MAIN]   <= bus.in_rs1;
        rs2_reg[MAIN]   <= bus.in_rs2;
        rd_reg[MAIN]    <= bus.in_rd;
        op1_reg[MAIN]   <= in_op1;
        op2_reg[MAIN]   <= in_op2;
        valid_reg[MAIN] <= 1'b1;
      end else if (push) begin
        pc_reg[SKID]    <= bus.in_pc;
        imm_reg[SKID]   <= bus.in_imm;
        ctrl_reg[SKID]  <= bus.in_ctrl;
        rs1_reg[SKID]   <= bus.in_rs1;
        rs2_reg[SKID]   <= bus.in_rs2;
        rd_reg[SKID]    <= bus.in_rd;
        op1_reg[SKID]   <= in_op1;
        op2_reg[SKID]   <= in_op2;
        valid_reg[SKID] <= 1'b1;
      end else if (pop) begin
        valid_reg[MAIN] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and random checks of id_ex_stage against a two-deep FIFO model with
// writeback forwarding applied to every queued instruction.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [15:0] ctrl;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] op1;
    logic [63:0] op2;
  } ent_t;

  ent_t q[$];
  bit   zero_data = 1'b1;

  id_ex_stage_if #(.SIZE(64), .CTRL_W(16)) bus ();
  id_ex_stage #(.SIZE(64), .CTRL_W(16)) dut (.CLK(clk), .RST(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fwd(logic [4:0] rs, logic [63:0] cur);
    if (rs == 5'd0) return 64'd0;
    if (bus.wb_we && bus.wb_rd == rs) return bus.wb_din;
    return cur;
  endfunction

  task automatic set_in(logic v, logic [63:0] pc, logic [4:0] rs1, logic [4:0] rs2,
                        logic [4:0] rd, logic [63:0] d1, logic [63:0] d2);
    bus.in_valid = v;
    bus.in_pc    = pc;
    bus.in_imm   = ~pc;
    bus.in_ctrl  = pc[15:0] ^ 16'h5a5a;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_rd    = rd;
    bus.rf_d1    = d1;
    bus.rf_d2    = d2;
  endtask

  task automatic set_wb(logic we, logic [4:0] rd, logic [63:0] din);
    bus.wb_we  = we;
    bus.wb_rd  = rd;
    bus.wb_din = din;
  endtask

  // Advance one clock: update the model from the inputs present at the edge, then compare.
  task automatic step();
    ent_t e;
    bit   push_ok;
    bit   pop_ok;
    if (rst) begin
      q.delete();
      zero_data = 1'b1;
    end else if (bus.flush) begin
      q.delete();
    end else begin
      push_ok = bus.in_valid && (q.size() < 2);
      pop_ok  = (q.size() > 0) && bus.out_ready;
      e.pc = bus.in_pc; e.imm = bus.in_imm; e.ctrl = bus.in_ctrl;
      e.rs1 = bus.in_rs1; e.rs2 = bus.in_rs2; e.rd = bus.in_rd;
      e.op1 = fwd(bus.in_rs1, bus.rf_d1);
      e.op2 = fwd(bus.in_rs2, bus.rf_d2);
      for (int i = 0; i < q.size(); i++) begin
        ent_t h;
        h = q[i];
        h.op1 = fwd(h.rs1, h.op1);
        h.op2 = fwd(h.rs2, h.op2);
        q[i] = h;
      end
      if (pop_ok) void'(q.pop_front());
      if (push_ok) begin
        q.push_back(e);
        zero_data = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("in_ready", bus.in_ready, q.size() < 2);
    chk("out_valid", bus.out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("out_pc", bus.out_pc, q[0].pc);
      chk("out_imm", bus.out_imm, q[0].imm);
      chk("out_ctrl", bus.out_ctrl, q[0].ctrl);
      chk("out_rs1", bus.out_rs1, q[0].rs1);
      chk("out_rs2", bus.out_rs2, q[0].rs2);
      chk("out_rd", bus.out_rd, q[0].rd);
      chk("out_op1", bus.out_op1, q[0].op1);
      chk("out_op2", bus.out_op2, q[0].op2);
    end else if (zero_data) begin
      chk("rst_pc", bus.out_pc, 64'd0);
      chk("rst_op1", bus.out_op1, 64'd0);
      chk("rst_op2", bus.out_op2, 64'd0);
      chk("rst_ctrl", bus.out_ctrl, 64'd0);
    end
  endtask

  initial begin
    set_in(1'b0, 64'd0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0);
    set_wb(1'b0, 5'd0, 64'd0);
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;

    // reset state
    rst = 1'b1; step(); step();
    rst = 1'b0;

    // x0 operand and plain register read
    set_in(1'b1, 64'h100, 5'd5, 5'd0, 5'd1, 64'h11, 64'hFF);
    step();
    chk("r031_op1", bus.out_op1, 64'h11);
    chk("r031_op2", bus.out_op2, 64'h0);
    set_in(1'b0, 64'd0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0);
    bus.out_ready = 1'b1; step();

    // same-cycle writeback forwarded on capture
    bus.out_ready = 1'b0;
    set_in(1'b1, 64'h200, 5'd7, 5'd0, 5'd2, 64'h3, 64'h0);
    set_wb(1'b1, 5'd7, 64'hAB);
    step();
    chk("r032_op1", bus.out_op1, 64'hAB);
    set_wb(1'b0, 5'd0, 64'd0);
    set_in(1'b0, 64'd0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0);
    bus.out_ready = 1'b1; step();

    // held entry picks up a later writeback
    bus.out_ready = 1'b0;
    set_in(1'b1, 64'h300, 5'd0, 5'd9, 5'd3, 64'h0, 64'h1);
    step();
    set_in(1'b0, 64'd0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0);
    step();
    set_wb(1'b1, 5'd9, 64'h55); step();
    set_wb(1'b0, 5'd0, 64'd0);
    chk("r033_op2", bus.out_op2, 64'h55);
    bus.out_ready = 1'b1; step();

    // skid fills, then drains in order
    bus.out_ready = 1'b0;
    set_in(1'b1, 64'hA00, 5'd1, 5'd2, 5'd4, 64'hA1, 64'hA2); step();
    set_in(1'b1, 64'hB00, 5'd3, 5'd4, 5'd5, 64'hB1, 64'hB2); step();
    chk("r034_ready_full", bus.in_ready, 1'b0);
    set_in(1'b0, 64'd0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0);
    bus.out_ready = 1'b1;
    chk("r034_first", bus.out_pc, 64'hA00);
    step();
    chk("r034_second", bus.out_pc, 64'hB00);
    step();
    chk("r034_ready_back", bus.in_ready, 1'b1);

    // flush discards both entries and the incoming one
    bus.out_ready = 1'b0;
    set_in(1'b1, 64'hC00, 5'd1, 5'd1, 5'd1, 64'h1, 64'h1); step();
    set_in(1'b1, 64'hD00, 5'd1, 5'd1, 5'd1, 64'h1, 64'h1); step();
    set_in(1'b1, 64'hE00, 5'd1, 5'd1, 5'd1, 64'h1, 64'h1);
    bus.flush = 1'b1; step();
    bus.flush = 1'b0;
    chk("r035_valid", bus.out_valid, 1'b0);
    chk("r035_ready", bus.in_ready, 1'b1);
    set_in(1'b0, 64'd0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0);
    step();

    // reset while an entry is held
    set_in(1'b1, 64'hF00, 5'd6, 5'd6, 5'd6, 64'h66, 64'h67); step();
    set_in(1'b1, 64'hF10, 5'd6, 5'd6, 5'd6, 64'h66, 64'h67);
    rst = 1'b1; step();
    rst = 1'b0;
    chk("r036_valid", bus.out_valid, 1'b0);
    chk("r036_op1", bus.out_op1, 64'h0);
    chk("r036_ready", bus.in_ready, 1'b1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.flush = ($urandom_range(0, 24) == 0);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      set_in($urandom_range(0, 2) != 0, {$urandom, $urandom},
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
             {$urandom, $urandom}, {$urandom, $urandom});
      set_wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), {$urandom, $urandom});
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter SIZE, default 64, operand/PC width.
REQ-002 SHALL have parameter CTRL_W, default 16, width of decoded control bundle.
REQ-003 SHALL have one clock and a synchronous, active-high reset: CLK  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have RST  input  1  synchronous active-high reset.
REQ-005 SHALL have in_valid  input  1  decode offers an instruction.
REQ-006 SHALL have in_ready  output  1  stage accepts this cycle.
REQ-007 SHALL have in_pc  input  SIZE, in_imm  input  SIZE, in_ctrl  input  CTRL_W  decoded fields.
REQ-008 SHALL have in_rs1, in_rs2, in_rd  input  5 each  register selectors; rs1/rs2 also drive regfile read ports.
REQ-009 SHALL have rf_d1, rf_d2  input  SIZE  regfile read data for in_rs1/in_rs2.
REQ-010 SHALL have wb_we  input  1, wb_rd  input  5, wb_din  input  SIZE  writeback bus, same signals driving regfile WE/rd/Din.
REQ-011 SHALL have flush  input  1  kill all held and incoming instructions.
REQ-012 SHALL have out_valid  output  1, out_ready  input  1  execute handshake.
REQ-013 SHALL have out_pc, out_imm, out_op1, out_op2  output  SIZE; out_ctrl  output  CTRL_W; out_rs1, out_rs2, out_rd  output  5.

Function
REQ-014 SHALL hold two entries: main (drives outputs) and skid; each entry = valid, pc, imm, ctrl, rs1, rs2, rd, op1, op2.
REQ-015 SHALL drive in_ready = NOT skid.valid, from registered state only (no combinational path from out_ready).
REQ-016 SHALL drive out_valid = main.valid; outputs are main fields directly from flops.
REQ-017 SHALL accept (push) when in_valid AND in_ready; pop when out_valid AND out_ready.
REQ-018 Capture operand: rs==0 -> 0; else wb_we AND wb_rd==rs -> wb_din; else rf_d value (covers write-and-read in same cycle).
REQ-019 Held entries: each cycle, if wb_we AND wb_rd==entry.rs AND rs!=0, that operand SHALL update to wb_din.
REQ-020 Push into empty stage or push with simultaneous pop of sole entry -> new data in main, skid empty.
REQ-021 Push while main held and not popped -> data into skid; in_ready low next cycle.
REQ-022 Pop with skid valid -> skid moves to main (with REQ-019 bypass applied), skid empties; push blocked that cycle.
REQ-023 Pop with no push and skid empty -> main.valid clears next cycle.
REQ-024 Latency: accepted instruction visible on outputs exactly 1 cycle after acceptance when stage empty.
REQ-025 flush SHALL clear main.valid and skid.valid next cycle, discarding any same-cycle push; flush overrides push/pop.
REQ-026 Data fields of invalid entries are don't-care, but SHALL never produce X after reset.

Reset
REQ-027 RST high at a clock edge SHALL clear both entries entirely: out_valid=0, in_ready=1, all output data 0.
REQ-028 RST SHALL override flush, push and pop, including mid-transfer.

Structure
REQ-029 SIZE default, CTRL_W and X0 index SHALL live in shared package datapath_pkg.
REQ-030 Bypass compare/mux SHALL be one combinational sub-module operand_bypass (rs, wb_we, wb_rd, wb_din, cur -> next), instantiated per operand per entry.

Verification
REQ-031 Push rs1=5, rs2=0, rf_d1=0x11, rf_d2=0xFF, no wb -> next cycle out_op1=0x11, out_op2=0.
REQ-032 Push rs1=7 with wb_we=1, wb_rd=7, wb_din=0xAB same cycle, rf_d1=0x3 -> out_op1=0xAB.
REQ-033 out_ready=0, hold entry rs2=9; two cycles later wb writes x9=0x55 -> out_op2=0x55 when popped.
REQ-034 out_ready=0, push A then B -> in_ready=0 after B; raise out_ready -> A then B emitted in order, in_ready back to 1.
REQ-035 Two entries held, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, incoming discarded.
REQ-036 Entry held, RST=1 one cycle -> out_valid=0, out_op1=0, in_ready=1.
